// File: rtl/lfsr_stream_xor_pkg.sv
// rtl/lfsr_stream_xor_pkg.sv - shared constants and state encoding for the keystream XOR stage
package lfsr_stream_xor_pkg;

  // Width of the keystream byte delivered by the sibling LFSR.
  localparam int KS_W = 8;

  // A 320x240 frame of 8-bit pixels.
  localparam int unsigned FRAME_BYTES_DEF = 76800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_stream_xor.sv
// rtl/lfsr_stream_xor.sv - XORs the LFSR keystream onto a framed byte stream and steers the LFSR
module lfsr_stream_xor
  import lfsr_stream_xor_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int unsigned CNT_W       = 17
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_bypass,
  input  logic [KS_W-1:0] cfg_key,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  input  logic            in_sof,
  input  logic            in_eof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            out_sof,
  output logic            out_eof,
  output logic            ks_enable,
  output logic            ks_pause,
  output logic            ks_load,
  output logic [KS_W-1:0] ks_ldata,
  input  logic [KS_W-1:0] ks_data,
  output logic            frame_err,
  output logic [15:0]     frame_cnt
);

  // Comparing in CNT_W+1 bits keeps a saturated counter from aliasing onto the frame length.
  localparam logic [CNT_W:0]   FRAME_LEN = (CNT_W+1)'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eof_q, out_eof_d;
  logic            frame_err_q, frame_err_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic            accept;
  logic            sof_restart;
  logic [CNT_W:0]  cnt_plus1;

  assign cnt_plus1 = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  // A sof beat arriving after the first byte aborts the frame; sof+eof together is handled as eof.
  assign sof_restart = (state_q == ST_RUN) && in_valid && in_sof && !in_eof && (cnt_q != '0);

  // Next-state, handshake and LFSR control decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    ks_enable   = 1'b0;
    ks_load     = 1'b0;
    ks_ldata    = '0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            state_d = ST_LOAD;
          end else begin
            // Stray byte outside a frame: swallow it so upstream cannot lock up.
            in_ready    = 1'b1;
            frame_err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        ks_enable = 1'b1;
        ks_load   = 1'b1;
        ks_ldata  = cfg_key;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        ks_enable = 1'b1;
        if (sof_restart) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_LOAD;
        end else begin
          in_ready = !out_valid_q || out_ready;
          accept   = in_valid && (!out_valid_q || out_ready);
          if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = cfg_bypass ? in_data : (in_data ^ ks_data);
            out_sof_d   = in_sof;
            out_eof_d   = in_eof;
            if (in_eof) begin
              if (cnt_plus1 != FRAME_LEN) begin
                frame_err_d = 1'b1;
              end
              frame_cnt_d = frame_cnt_q + 16'd1;
              cnt_d       = '0;
              state_d     = ST_IDLE;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The LFSR steps only on the edge that consumes a byte.
  assign ks_pause = !accept;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lfsr_stream_xor.sv
// tb/tb_lfsr_stream_xor.sv - directed bench for lfsr_stream_xor with behavioural LFSR siblings
module tb_lfsr_stream_xor;

  localparam logic [7:0] SEED = 8'h01;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_bypass = 1'b0;
  logic [7:0] cfg_key = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sof = 1'b0;
  logic       in_eof = 1'b0;
  logic       out_ready = 1'b1;
  logic       sel = 1'b0;

  logic       in_ready1, out_valid1, out_sof1, out_eof1, ks_en1, ks_pause1, ks_load1, frame_err1;
  logic [7:0] out_data1, ks_ldata1, lq1;
  logic [15:0] frame_cnt1;
  logic       in_ready2, out_valid2, out_sof2, out_eof2, ks_en2, ks_pause2, ks_load2, frame_err2;
  logic [7:0] out_data2, ks_ldata2, lq2;
  logic [15:0] frame_cnt2;

  logic       in_ready, out_valid, out_sof, out_eof, ks_enable, ks_pause, ks_load, frame_err;
  logic [7:0] out_data, ks_ldata;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int pause_low = 0;
  int load_cnt = 0;
  int hold_chk = 0;
  int hold_bad = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic       toggle_en = 1'b0;
  logic [3:0] pat = 4'b1001;
  int         ph = 0;
  logic [9:0] outq[$];
  logic [9:0] expq[$];
  logic [7:0] ct[4];

  lfsr_stream_xor #(.FRAME_BYTES(4), .CNT_W(17)) dut1 (
    .clk(clk), .reset(reset), .cfg_bypass(cfg_bypass), .cfg_key(cfg_key),
    .in_valid(in_valid & !sel), .in_ready(in_ready1), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_sof(out_sof1), .out_eof(out_eof1),
    .ks_enable(ks_en1), .ks_pause(ks_pause1), .ks_load(ks_load1), .ks_ldata(ks_ldata1),
    .ks_data(lq1), .frame_err(frame_err1), .frame_cnt(frame_cnt1)
  );

  lfsr_stream_xor #(.FRAME_BYTES(4), .CNT_W(17)) dut2 (
    .clk(clk), .reset(reset), .cfg_bypass(cfg_bypass), .cfg_key(cfg_key),
    .in_valid(in_valid & sel), .in_ready(in_ready2), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_sof(out_sof2), .out_eof(out_eof2),
    .ks_enable(ks_en2), .ks_pause(ks_pause2), .ks_load(ks_load2), .ks_ldata(ks_ldata2),
    .ks_data(lq2), .frame_err(frame_err2), .frame_cnt(frame_cnt2)
  );

  assign in_ready  = sel ? in_ready2  : in_ready1;
  assign out_valid = sel ? out_valid2 : out_valid1;
  assign out_data  = sel ? out_data2  : out_data1;
  assign out_sof   = sel ? out_sof2   : out_sof1;
  assign out_eof   = sel ? out_eof2   : out_eof1;
  assign ks_enable = sel ? ks_en2     : ks_en1;
  assign ks_pause  = sel ? ks_pause2  : ks_pause1;
  assign ks_load   = sel ? ks_load2   : ks_load1;
  assign ks_ldata  = sel ? ks_ldata2  : ks_ldata1;
  assign frame_err = sel ? frame_err2 : frame_err1;
  assign frame_cnt = sel ? frame_cnt2 : frame_cnt1;

  function automatic logic [7:0] lstep(input logic [7:0] q);
    return {q[6:0], 1'b0} ^ (q[7] ? 8'h1D : 8'h00);
  endfunction

  always #5 clk = ~clk;

  // Behavioural 8-bit Galois LFSRs (poly 0x1D): disable forces seed, load wins over step.
  always @(posedge clk) begin
    if (reset || !ks_en1) lq1 <= SEED;
    else if (ks_load1)    lq1 <= ks_ldata1;
    else if (!ks_pause1)  lq1 <= lstep(lq1);
    if (reset || !ks_en2) lq2 <= SEED;
    else if (ks_load2)    lq2 <= ks_ldata2;
    else if (!ks_pause2)  lq2 <= lstep(lq2);
  end

  // Observe on the falling edge: output transfers, LFSR steps, LOAD cycles, stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      if (!ks_pause) pause_low++;
      if (ks_load) load_cnt++;
      if (out_valid && out_ready) outq.push_back({out_sof, out_eof, out_data});
      if (prev_hold) begin
        hold_chk++;
        if (!(out_valid && out_data == prev_d)) hold_bad++;
      end
      prev_hold = out_valid && !out_ready;
      prev_d    = out_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) begin
      out_ready = pat[ph];
      ph = (ph + 1) % 4;
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic e);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    in_eof   = e;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    check("beat_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic clear_mon();
    outq.delete();
    pause_low = 0;
    load_cnt  = 0;
    hold_chk  = 0;
    hold_bad  = 0;
  endtask

  task automatic check_outq(input string tag);
    logic [31:0] obs;
    check({tag, "_count"}, outq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      obs = (i < outq.size()) ? {22'd0, outq[i]} : 32'hFFFF_FFFF;
      check($sformatf("%s[%0d]", tag, i), obs, {22'd0, expq[i]});
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_ks_enable", ks_enable, 1'b0);
    check("rst_ks_pause", ks_pause, 1'b1);
    check("rst_ks_load", ks_load, 1'b0);
    check("rst_ks_ldata", ks_ldata, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_in_ready", in_ready, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // Frame of zeros, key 0x20: output is the raw keystream
    cfg_key = 8'h20;
    clear_mon();
    beat(8'h00, 1'b1, 1'b0);
    beat(8'h00, 1'b0, 1'b0);
    beat(8'h00, 1'b0, 1'b0);
    beat(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("f1_ks_enable_idle", ks_enable, 1'b0);
    tick();
    repeat (3) tick();
    expq = '{{2'b10, 8'h20}, {2'b00, 8'h40}, {2'b00, 8'h80}, {2'b01, 8'h1D}};
    check_outq("f1_out");
    check("f1_pause_low", pause_low, 4);
    check("f1_load_cycles", load_cnt, 1);
    check("f1_frame_err", frame_err, 1'b0);
    check("f1_frame_cnt", frame_cnt, 16'd1);
    for (int i = 0; i < 4; i++) ct[i] = outq[i][7:0];

    // Same frame with downstream backpressure 1,0,0,1
    clear_mon();
    toggle_en = 1'b1;
    out_ready = pat[0];
    ph = 1;
    beat(8'h00, 1'b1, 1'b0);
    beat(8'h00, 1'b0, 1'b0);
    beat(8'h00, 1'b0, 1'b0);
    beat(8'h00, 1'b0, 1'b1);
    repeat (8) tick();
    toggle_en = 1'b0;
    out_ready = 1'b1;
    tick();
    check_outq("f2_out");
    check("f2_pause_low", pause_low, 4);
    check("f2_stall_seen", {31'd0, (hold_chk > 0)}, 32'd1);
    check("f2_stall_stable", hold_bad, 0);
    check("f2_frame_cnt", frame_cnt, 16'd2);

    // Ciphertext through the second instance with the same key decrypts to zeros
    sel = 1'b1;
    tick();
    clear_mon();
    beat(ct[0], 1'b1, 1'b0);
    beat(ct[1], 1'b0, 1'b0);
    beat(ct[2], 1'b0, 1'b0);
    beat(ct[3], 1'b0, 1'b1);
    repeat (4) tick();
    expq = '{{2'b10, 8'h00}, {2'b00, 8'h00}, {2'b00, 8'h00}, {2'b01, 8'h00}};
    check_outq("dec_out");
    check("dec_frame_err", frame_err, 1'b0);
    sel = 1'b0;
    tick();

    // Bypass: data passes unchanged while the keystream still steps
    cfg_bypass = 1'b1;
    clear_mon();
    beat(8'hA5, 1'b1, 1'b0);
    beat(8'h5A, 1'b0, 1'b0);
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'h00, 1'b0, 1'b1);
    repeat (4) tick();
    expq = '{{2'b10, 8'hA5}, {2'b00, 8'h5A}, {2'b00, 8'hFF}, {2'b01, 8'h00}};
    check_outq("byp_out");
    check("byp_pause_low", pause_low, 4);
    check("byp_frame_cnt", frame_cnt, 16'd3);
    cfg_bypass = 1'b0;

    // sof on the third byte: error, reload, restarted frame keyed from cfg_key again
    clear_mon();
    beat(8'h11, 1'b1, 1'b0);
    beat(8'h12, 1'b0, 1'b0);
    beat(8'h13, 1'b1, 1'b0);
    beat(8'h14, 1'b0, 1'b0);
    beat(8'h15, 1'b0, 1'b0);
    beat(8'h16, 1'b0, 1'b1);
    repeat (4) tick();
    expq = '{{2'b10, 8'h31}, {2'b00, 8'h52}, {2'b10, 8'h33},
             {2'b00, 8'h54}, {2'b00, 8'h95}, {2'b01, 8'h0B}};
    check_outq("sof_out");
    check("sof_load_cycles", load_cnt, 2);
    check("sof_pause_low", pause_low, 6);
    check("sof_frame_err", frame_err, 1'b1);
    check("sof_frame_cnt", frame_cnt, 16'd4);

    // Reset clears the sticky error and frame count
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst2_frame_err", frame_err, 1'b0);
    check("rst2_frame_cnt", frame_cnt, 16'd0);
    tick();
    reset = 1'b0;
    tick();

    // Short frame: eof after 3 bytes flags a length error but still counts the frame
    clear_mon();
    beat(8'h21, 1'b1, 1'b0);
    beat(8'h22, 1'b0, 1'b0);
    beat(8'h23, 1'b0, 1'b1);
    @(negedge clk);
    check("short_ks_enable", ks_enable, 1'b0);
    tick();
    repeat (3) tick();
    expq = '{{2'b10, 8'h01}, {2'b00, 8'h62}, {2'b01, 8'hA3}};
    check_outq("short_out");
    check("short_pause_low", pause_low, 3);
    check("short_frame_err", frame_err, 1'b1);
    check("short_frame_cnt", frame_cnt, 16'd1);

    // Stray byte in IDLE is consumed, not forwarded, and flags an error
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    clear_mon();
    beat(8'h77, 1'b0, 1'b0);
    repeat (4) tick();
    check("stray_out_count", outq.size(), 0);
    check("stray_pause_low", pause_low, 0);
    check("stray_frame_err", frame_err, 1'b1);
    check("stray_frame_cnt", frame_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_xor.md
Name: lfsr_stream_xor

Overview:
- Keystream cipher stage directly downstream of the 8-bit LFSR keystream generator.
- Consumes the LFSR's current 8-bit output and XORs it onto an 8-bit pixel byte stream under a valid/ready handshake.
- Drives the LFSR's enable/pause/load controls so that the keystream advances exactly once per accepted byte and reseeds at every start of frame.
- Sits between the video capture byte stream and the SDRAM write path. The same block decrypts on readback because XOR is symmetric.

Parameters:
- FRAME_BYTES, 76800, expected bytes per frame (a 320x240 8-bit frame); used only for length checking.
- CNT_W, 17, width of the frame byte counter; must satisfy 2^CNT_W > FRAME_BYTES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_bypass  in  1  1 = pass data unencrypted; keystream is still advanced
- cfg_key  in  8  per-frame seed, sampled in LOAD state
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted when in_valid & in_ready
- in_data  in  8  plaintext byte
- in_sof  in  1  first byte of frame (qualified by in_valid)
- in_eof  in  1  last byte of frame (qualified by in_valid)
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accept
- out_data  out  8  ciphertext byte
- out_sof  out  1  registered copy of in_sof
- out_eof  out  1  registered copy of in_eof
- ks_enable  out  1  to LFSR enable; 0 forces the LFSR to its seed
- ks_pause  out  1  to LFSR pause
- ks_load  out  1  to LFSR load
- ks_ldata  out  8  to LFSR ldata
- ks_data  in  8  LFSR current output (registered in the LFSR)
- frame_err  out  1  sticky: frame length mismatch or sof mid-frame; cleared only by reset
- frame_cnt  out  16  count of completed frames; wraps at 65535->0

Behaviour:
- Reset values:
  - state=IDLE; out_valid=0; out_data=0; out_sof=0; out_eof=0.
  - ks_enable=0; ks_load=0; ks_pause=1; ks_ldata=0.
  - frame_err=0; frame_cnt=0; byte counter=0.
- FSM states: IDLE, LOAD, RUN.
  - IDLE:
    - in_ready=0, ks_enable=0.
    - If in_valid & in_sof: go to LOAD.
    - In_valid without sof: in_ready=1, the byte is dropped (consumed, not forwarded), and frame_err is set.
  - LOAD (exactly 1 cycle):
    - in_ready=0; ks_enable=1; ks_load=1; ks_ldata=cfg_key.
    - Next state RUN. From the first RUN cycle, ks_data==cfg_key.
  - RUN:
    - in_ready = !out_valid | out_ready.
    - On accept: out_data <= in_data ^ ks_data, or in_data if cfg_bypass. out_sof/out_eof register the inputs. out_valid <= 1. ks_pause=0 in the same cycle so the LFSR steps at that edge. Byte counter increments.
    - No accept: ks_pause=1. The output holds while out_valid & !out_ready.
    - ks_pause is combinational: !(in_valid & in_ready & state==RUN).
    - out_valid clears when out_ready=1 and no new accept occurs.
  - Latency: 1 cycle from input accept to out_valid. Full throughput of 1 byte/cycle in RUN with out_ready held high.
- End of frame: accepted beat with in_eof=1 in RUN.
  - If counter+1 != FRAME_BYTES, set frame_err.
  - frame_cnt increments; counter clears; next state IDLE; ks_enable deasserts in IDLE, parking the LFSR at its seed.
- sof while in RUN (not on the first byte):
  - Byte is not accepted (in_ready forced 0); frame_err is set; counter clears; next state LOAD, then the frame restarts.
- sof & eof on the same beat in RUN (single-byte frame): treated as eof; length check applies.
- Byte counter saturates at 2^CNT_W-1 and never wraps. Saturation leaves the mismatch in place, so the eof length check still flags the error.
- cfg_key change: only the value sampled in LOAD matters. cfg_bypass is sampled per accepted byte.
- Reset mid-frame: all state returns to reset values in the next cycle, and any pending output byte is discarded.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2;
  - KS_W=8;
  - default FRAME_BYTES.
- No sub-module. The LFSR stays a separate sibling instance wired to the ks_* ports. The bench instantiates both together.

Test Plan:
- Reset, then a frame with cfg_key=8'h20, FRAME_BYTES=4, data 00,00,00,00, out_ready=1 -> out_data 20,40,80,1D (LFSR sequence from 0x20); frame_err=0; frame_cnt=1.
- Same frame with out_ready toggled 1,0,0,1 each cycle -> identical output sequence; out_data stable while stalled; exactly 4 LFSR steps, checked by ks_pause low count =4.
- Ciphertext from the first test fed back through a second instance with the same key -> recovers 00,00,00,00.
- cfg_bypass=1, data A5,5A,FF,00 -> out_data equals input; ks_pause low 4 times.
- sof asserted on byte 3 of a 4-byte frame -> frame_err=1; LOAD cycle observed; restarted frame's first byte XORed with cfg_key.
- eof after 3 bytes with FRAME_BYTES=4 -> frame_err=1; frame_cnt increments; state returns to IDLE with ks_enable=0.
